// File: rtl/vend_ctrl_multi_if.sv
// Strobe inputs from the coin/button debouncers and outputs to the dispenser/display drivers.
// The controller takes the slave side; the upstream/downstream logic takes the master side.
interface vend_ctrl_multi_if #(
  parameter int NUM_ITEMS = 3,
  parameter int AMT_W     = 8,
  parameter int TOTAL_W   = 16,
  parameter int SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
);
  logic                 coin_valid;
  logic [1:0]           coin_type;
  logic                 sel_valid;
  logic [SEL_W-1:0]     sel_idx;
  logic                 cancel;
  logic                 clr_total;
  logic [NUM_ITEMS-1:0] vend;
  logic                 busy;
  logic [AMT_W-1:0]     credit;
  logic                 change_valid;
  logic [AMT_W-1:0]     change_amt;
  logic                 coin_reject;
  logic                 sel_err;
  logic [TOTAL_W-1:0]   total_acc;
  logic [TOTAL_W-1:0]   last_total;

  modport master (
    output coin_valid, coin_type, sel_valid, sel_idx, cancel, clr_total,
    input  vend, busy, credit, change_valid, change_amt, coin_reject, sel_err,
           total_acc, last_total
  );

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel_idx, cancel, clr_total,
    output vend, busy, credit, change_valid, change_amt, coin_reject, sel_err,
           total_acc, last_total
  );
endinterface

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: coin accumulation, item select, timed vend line,
// optional change/cancel, and a saturating sales total with operator snapshot/clear.
module vend_ctrl_multi #(
  parameter int NUM_ITEMS     = 3,
  parameter int PRICE         = 70,
  parameter int VEND_CYCLES   = 100,
  parameter int AMT_W         = 8,
  parameter int TOTAL_W       = 16,
  parameter int RETURN_CHANGE = 0,
  parameter int SEL_W         = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input logic              clk,
  input logic              reset,
  vend_ctrl_multi_if.slave bus
);

  localparam int              CNT_W    = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(VEND_CYCLES - 1);
  localparam logic [AMT_W-1:0] PRICE_A  = AMT_W'(PRICE);
  localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(NUM_ITEMS);
  localparam bit               RET      = (RETURN_CHANGE != 0);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    SELECT = 2'd1,
    VEND   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [AMT_W-1:0]     credit, credit_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [NUM_ITEMS-1:0] vend_r, vend_nxt;
  logic                 change_valid, change_valid_nxt;
  logic [AMT_W-1:0]     change_amt, change_amt_nxt;
  logic                 coin_reject, coin_reject_nxt;
  logic                 sel_err, sel_err_nxt;
  logic [TOTAL_W-1:0]   total_acc, total_nxt;
  logic [TOTAL_W-1:0]   last_total, last_nxt;

  logic                 sel_ok;
  logic                 cancel_ok;
  logic [AMT_W-1:0]     coin_sum;
  logic [NUM_ITEMS-1:0] sel_onehot;

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] t);
    case (t)
      2'b00:   coin_value = AMT_W'(5);
      2'b01:   coin_value = AMT_W'(10);
      2'b10:   coin_value = AMT_W'(25);
      default: coin_value = AMT_W'(100);
    endcase
  endfunction

  // The sales total sticks at all-ones rather than wrapping.
  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                 input logic [AMT_W-1:0]   b);
    logic [TOTAL_W:0] s;
    s = {1'b0, a} + (TOTAL_W + 1)'(b);
    sat_add = s[TOTAL_W] ? {TOTAL_W{1'b1}} : s[TOTAL_W-1:0];
  endfunction

  assign sel_ok     = ({1'b0, bus.sel_idx} < SEL_LIM);
  assign sel_onehot = {{(NUM_ITEMS-1){1'b0}}, 1'b1} << bus.sel_idx;
  assign coin_sum   = credit + coin_value(bus.coin_type);
  // Cancel only counts when it would actually hand money back.
  assign cancel_ok  = RET && bus.cancel && (state != VEND) && (credit != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ACCEPT;
      credit       <= '0;
      cnt          <= '0;
      vend_r       <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      total_acc    <= '0;
      last_total   <= '0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      cnt          <= cnt_nxt;
      vend_r       <= vend_nxt;
      change_valid <= change_valid_nxt;
      change_amt   <= change_amt_nxt;
      coin_reject  <= coin_reject_nxt;
      sel_err      <= sel_err_nxt;
      total_acc    <= total_nxt;
      last_total   <= last_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    cnt_nxt          = cnt;
    vend_nxt         = vend_r;
    change_valid_nxt = 1'b0;
    change_amt_nxt   = change_amt;
    coin_reject_nxt  = 1'b0;
    sel_err_nxt      = 1'b0;
    total_nxt        = total_acc;
    last_nxt         = last_total;

    if (bus.clr_total) begin
      last_nxt        = total_acc;
      total_nxt       = '0;
      credit_nxt      = '0;
      vend_nxt        = '0;
      cnt_nxt         = '0;
      state_nxt       = ACCEPT;
      coin_reject_nxt = bus.coin_valid;
    end else if ((state == SELECT) && bus.sel_valid) begin
      coin_reject_nxt = bus.coin_valid;
      if (sel_ok) begin
        state_nxt  = VEND;
        vend_nxt   = sel_onehot;
        cnt_nxt    = CNT_LOAD;
        credit_nxt = '0;
        if (RET) begin
          change_amt_nxt   = credit - PRICE_A;
          change_valid_nxt = 1'b1;
          total_nxt        = sat_add(total_acc, PRICE_A);
        end else begin
          total_nxt        = sat_add(total_acc, credit);
        end
      end else begin
        sel_err_nxt = 1'b1;
      end
    end else if (cancel_ok) begin
      change_amt_nxt   = credit;
      change_valid_nxt = 1'b1;
      credit_nxt       = '0;
      state_nxt        = ACCEPT;
      coin_reject_nxt  = bus.coin_valid;
    end else begin
      case (state)
        ACCEPT: begin
          if (bus.coin_valid) begin
            credit_nxt = coin_sum;
            if (coin_sum >= PRICE_A) state_nxt = SELECT;
          end
        end
        SELECT: begin
          coin_reject_nxt = bus.coin_valid;
        end
        VEND: begin
          coin_reject_nxt = bus.coin_valid;
          if (cnt == '0) begin
            vend_nxt  = '0;
            state_nxt = ACCEPT;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          vend_nxt  = '0;
          state_nxt = ACCEPT;
        end
      endcase
    end
  end

  assign bus.vend         = vend_r;
  assign bus.busy         = (state == VEND);
  assign bus.credit       = credit;
  assign bus.change_valid = change_valid;
  assign bus.change_amt   = change_amt;
  assign bus.coin_reject  = coin_reject;
  assign bus.sel_err      = sel_err;
  assign bus.total_acc    = total_acc;
  assign bus.last_total   = last_total;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: one keep-excess instance and one change-returning instance
// (narrow 8-bit total so saturation is reachable) driven by the same strobes.
module tb_vend_ctrl_multi;
  localparam int N     = 3;
  localparam int PRICE = 70;
  localparam int VC    = 100;

  logic clk;
  logic reset;

  vend_ctrl_multi_if #(.NUM_ITEMS(N), .AMT_W(8), .TOTAL_W(16)) if0 ();
  vend_ctrl_multi_if #(.NUM_ITEMS(N), .AMT_W(8), .TOTAL_W(8))  if1 ();

  vend_ctrl_multi #(.NUM_ITEMS(N), .PRICE(PRICE), .VEND_CYCLES(VC), .AMT_W(8),
                    .TOTAL_W(16), .RETURN_CHANGE(0)) u_keep (.clk(clk), .reset(reset), .bus(if0));
  vend_ctrl_multi #(.NUM_ITEMS(N), .PRICE(PRICE), .VEND_CYCLES(VC), .AMT_W(8),
                    .TOTAL_W(8), .RETURN_CHANGE(1))  u_ret  (.clk(clk), .reset(reset), .bus(if1));

  assign if1.coin_valid = if0.coin_valid;
  assign if1.coin_type  = if0.coin_type;
  assign if1.sel_valid  = if0.sel_valid;
  assign if1.sel_idx    = if0.sel_idx;
  assign if1.cancel     = if0.cancel;
  assign if1.clr_total  = if0.clr_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: money and vending described directly, index 0 keeps excess, 1 returns change.
  int unsigned m_credit[2] = '{0, 0};
  int unsigned m_total[2]  = '{0, 0};
  int unsigned m_last[2]   = '{0, 0};
  int unsigned m_chg[2]    = '{0, 0};
  int          m_item[2]   = '{-1, -1};
  int          m_left[2]   = '{0, 0};
  bit          m_cv[2]     = '{0, 0};
  bit          m_rej[2]    = '{0, 0};
  bit          m_serr[2]   = '{0, 0};
  int unsigned t_max[2]    = '{65535, 255};

  function automatic int unsigned cents(input logic [1:0] t);
    case (t)
      2'd0:    return 5;
      2'd1:    return 10;
      2'd2:    return 25;
      default: return 100;
    endcase
  endfunction

  task automatic model_step(input int m, input bit cv, input logic [1:0] ct, input bit sv,
                            input logic [1:0] si, input bit ca, input bit clr);
    bit rc, vending, selecting;
    rc        = (m == 1);
    vending   = (m_item[m] >= 0);
    selecting = !vending && (m_credit[m] >= PRICE);
    m_cv[m]   = 0;
    m_rej[m]  = 0;
    m_serr[m] = 0;
    if (clr) begin
      m_last[m]   = m_total[m];
      m_total[m]  = 0;
      m_credit[m] = 0;
      m_item[m]   = -1;
      m_rej[m]    = cv;
    end else if (selecting && sv) begin
      m_rej[m] = cv;
      if (int'(si) < N) begin
        m_item[m] = int'(si);
        m_left[m] = VC;
        if (rc) begin
          m_chg[m]   = m_credit[m] - PRICE;
          m_cv[m]    = 1;
          m_total[m] = (m_total[m] + PRICE > t_max[m]) ? t_max[m] : m_total[m] + PRICE;
        end else begin
          m_total[m] = (m_total[m] + m_credit[m] > t_max[m]) ? t_max[m] : m_total[m] + m_credit[m];
        end
        m_credit[m] = 0;
      end else begin
        m_serr[m] = 1;
      end
    end else if (rc && ca && !vending && m_credit[m] > 0) begin
      m_chg[m]    = m_credit[m];
      m_cv[m]     = 1;
      m_credit[m] = 0;
      m_rej[m]    = cv;
    end else if (vending) begin
      m_rej[m] = cv;
      m_left[m]--;
      if (m_left[m] == 0) m_item[m] = -1;
    end else if (cv) begin
      if (selecting) m_rej[m] = 1;
      else m_credit[m] += cents(ct);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_credit[m] = 0; m_total[m] = 0; m_last[m] = 0; m_chg[m] = 0;
        m_item[m] = -1; m_left[m] = 0; m_cv[m] = 0; m_rej[m] = 0; m_serr[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++)
        model_step(m, if0.coin_valid, if0.coin_type, if0.sel_valid, if0.sel_idx,
                   if0.cancel, if0.clr_total);
    end
  end

  task automatic cmp_inst(input int m, input logic [2:0] vend, input logic busy,
                          input logic [7:0] credit, input logic cv, input logic [7:0] camt,
                          input logic rej, input logic serr, input logic [15:0] tot,
                          input logic [15:0] last);
    string p;
    int unsigned ev;
    p  = (m == 1) ? "ret" : "keep";
    ev = (m_item[m] >= 0) ? (1 << m_item[m]) : 0;
    chk({p, ".vend"}, vend, ev);
    chk({p, ".busy"}, busy, (m_item[m] >= 0) ? 1 : 0);
    chk({p, ".credit"}, credit, m_credit[m]);
    chk({p, ".change_valid"}, cv, m_cv[m]);
    if (m_cv[m]) chk({p, ".change_amt"}, camt, m_chg[m]);
    chk({p, ".coin_reject"}, rej, m_rej[m]);
    chk({p, ".sel_err"}, serr, m_serr[m]);
    chk({p, ".total_acc"}, tot, m_total[m]);
    chk({p, ".last_total"}, last, m_last[m]);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      cmp_inst(0, if0.vend, if0.busy, if0.credit, if0.change_valid, if0.change_amt,
               if0.coin_reject, if0.sel_err, if0.total_acc, if0.last_total);
      cmp_inst(1, if1.vend, if1.busy, if1.credit, if1.change_valid, if1.change_amt,
               if1.coin_reject, if1.sel_err, {8'd0, if1.total_acc}, {8'd0, if1.last_total});
    end
  end

  task automatic drive(input bit cv, input logic [1:0] ct, input bit sv, input logic [1:0] si,
                       input bit ca, input bit clr);
    if0.coin_valid = cv; if0.coin_type = ct; if0.sel_valid = sv;
    if0.sel_idx = si; if0.cancel = ca; if0.clr_total = clr;
    @(posedge clk); #1;
    if0.coin_valid = 0; if0.sel_valid = 0; if0.cancel = 0; if0.clr_total = 0;
  endtask

  task automatic coin(input logic [1:0] ct); drive(1, ct, 0, 2'd0, 0, 0); endtask
  task automatic sel(input logic [1:0] i);   drive(0, 2'd0, 1, i, 0, 0); endtask
  task automatic idle();                     drive(0, 2'd0, 0, 2'd0, 0, 0); endtask

  task automatic wait_vend_end();
    int n;
    n = 0;
    while ((if0.vend != 0 || if1.vend != 0) && n < 300) begin
      idle();
      n++;
    end
    if (n >= 300) chk("vend_end_timeout", 1, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    if0.coin_valid = 0; if0.coin_type = 0; if0.sel_valid = 0;
    if0.sel_idx = 0; if0.cancel = 0; if0.clr_total = 0;
    #12;
    chk("rst.keep.vend", if0.vend, 0);
    chk("rst.keep.credit", if0.credit, 0);
    chk("rst.keep.total", if0.total_acc, 0);
    chk("rst.ret.last", if1.last_total, 0);
    chk("rst.ret.change_amt", if1.change_amt, 0);
    chk("rst.ret.busy", if1.busy, 0);
    #10 reset = 1'b0;

    // 25,25,10,10 -> 25,50,60,70, then SELECT rejects a further coin
    coin(2); chk("c1.credit", if0.credit, 25);
    coin(2); chk("c2.credit", if1.credit, 50);
    coin(1); chk("c3.credit", if0.credit, 60);
    coin(1); chk("c4.keep.credit", if0.credit, 70); chk("c4.ret.credit", if1.credit, 70);
    coin(0); chk("sel_state.reject", if0.coin_reject, 1); chk("sel_state.credit", if0.credit, 70);
    sel(1);
    chk("s1.vend", if0.vend, 3'b010);
    chk("s1.keep.total", if0.total_acc, 70);
    chk("s1.ret.total", if1.total_acc, 70);
    chk("s1.ret.change_valid", if1.change_valid, 1);
    chk("s1.ret.change_amt", if1.change_amt, 0);
    chk("s1.keep.change_valid", if0.change_valid, 0);
    chk("s1.credit", if0.credit, 0);
    n = 0;
    while (if0.vend != 0 && n < 300) begin
      n++;
      if (n == 10) begin if0.coin_valid = 1; if0.coin_type = 2; end
      @(posedge clk); #1;
      if (n == 10) begin
        if0.coin_valid = 0;
        chk("mid_vend.reject", if0.coin_reject, 1);
        chk("mid_vend.credit", if0.credit, 0);
      end
    end
    chk("vend_len", n, VC);

    // 100c then item 2: change 30 on the returning instance
    coin(3); sel(2);
    chk("s2.vend", if1.vend, 3'b100);
    chk("s2.ret.change_amt", if1.change_amt, 30);
    chk("s2.ret.change_valid", if1.change_valid, 1);
    chk("s2.ret.total", if1.total_acc, 140);
    chk("s2.keep.total", if0.total_acc, 170);
    idle(); chk("s2.change_pulse_len", if1.change_valid, 0);
    wait_vend_end();

    // Out-of-range selection then a valid one
    coin(2); coin(2); coin(2);
    sel(3);
    chk("s3.sel_err", if0.sel_err, 1);
    chk("s3.vend", if0.vend, 0);
    chk("s3.credit", if1.credit, 75);
    sel(0);
    chk("s3.vend_ok", if0.vend, 3'b001);
    chk("s3.keep.total", if0.total_acc, 245);
    chk("s3.ret.total", if1.total_acc, 210);
    wait_vend_end();

    // Narrow total saturates: 210+70 -> 255
    coin(3); sel(1);
    chk("sat.ret.total", if1.total_acc, 255);
    chk("sat.keep.total", if0.total_acc, 345);
    wait_vend_end();

    // Cancel returns credit only where change is enabled
    coin(2); coin(1);
    drive(0, 2'd0, 0, 2'd0, 1, 0);
    chk("cancel.ret.change_amt", if1.change_amt, 35);
    chk("cancel.ret.change_valid", if1.change_valid, 1);
    chk("cancel.ret.credit", if1.credit, 0);
    chk("cancel.keep.credit", if0.credit, 35);
    drive(0, 2'd0, 0, 2'd0, 1, 0);
    chk("cancel0.ret.change_valid", if1.change_valid, 0);

    drive(0, 2'd0, 0, 2'd0, 0, 1);
    chk("clr1.keep.last", if0.last_total, 345);
    chk("clr1.ret.last", if1.last_total, 255);
    chk("clr1.keep.credit", if0.credit, 0);

    // Two sales to 140, clear in the middle of the second vend
    coin(2); coin(2); coin(1); coin(1); sel(1); wait_vend_end();
    coin(2); coin(2); coin(1); coin(1); sel(2);
    repeat (5) idle();
    drive(0, 2'd0, 0, 2'd0, 0, 1);
    chk("clr2.vend", if0.vend, 0);
    chk("clr2.busy", if1.busy, 0);
    chk("clr2.keep.last", if0.last_total, 140);
    chk("clr2.ret.last", if1.last_total, 140);
    chk("clr2.total", if0.total_acc, 0);

    // Async reset in the middle of a vend
    coin(3); sel(0);
    repeat (3) idle();
    #2 reset = 1'b1;
    #1;
    chk("areset.vend", if0.vend, 0);
    chk("areset.busy", if0.busy, 0);
    chk("areset.total", if0.total_acc, 0);
    chk("areset.last", if1.last_total, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Randomised traffic against the model
    for (int i = 0; i < 8000; i++) begin
      drive($urandom_range(0, 99) < 30, 2'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 12, 2'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 5, $urandom_range(0, 199) < 1);
    end
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised successor to the single-item coin accumulator.
- Multi-item vending FSM: accepts coin strobes until credit reaches PRICE, waits for an item selection, then drives one vend line for VEND_CYCLES clocks.
- Optionally returns change and supports cancel.
- Keeps a running sales total, with a snapshot and clear on operator request.
- Sits between the coin-slot and button debouncers and the dispenser/display drivers, in the 100 Hz system clock domain.

Parameters:
- NUM_ITEMS, 3, number of selectable items / vend lines (2..16).
- PRICE, 70, item cost in cents; must be a multiple of 5.
- VEND_CYCLES, 100, clocks a vend line is held high (1 s at 100 Hz).
- AMT_W, 8, credit/change width; PRICE+95 < 2^AMT_W.
- TOTAL_W, 16, sales-total width.
- RETURN_CHANGE, 0, 1 = return excess credit and honour cancel; 0 = keep excess, cancel ignored.
- SEL_W, $clog2(NUM_ITEMS) (min 1), selection index width.

Ports:
- clk  in  1  system clock, 100 Hz.
- reset  in  1  asynchronous, active-high; clock clk.
- coin_valid  in  1  one-cycle coin strobe.
- coin_type  in  2  00=5c, 01=10c, 10=25c, 11=100c; sampled with coin_valid.
- sel_valid  in  1  one-cycle item-select strobe.
- sel_idx  in  SEL_W  selected item index.
- cancel  in  1  one-cycle cancel strobe.
- clr_total  in  1  one-cycle operator clear (the "press-and-release R" event, already synchronised).
- vend  out  NUM_ITEMS  one-hot vend lines.
- busy  out  1  high in VEND.
- credit  out  AMT_W  current credit.
- change_valid  out  1  one-cycle change strobe.
- change_amt  out  AMT_W  change value, valid with change_valid.
- coin_reject  out  1  one-cycle pulse: coin not accepted.
- sel_err  out  1  one-cycle pulse: out-of-range selection.
- total_acc  out  TOTAL_W  cents collected since last clear.
- last_total  out  TOTAL_W  total_acc captured at last clr_total.

Behaviour:
- Reset (async): state=ACCEPT. All outputs 0, including credit, total_acc and last_total.
- States:
  - ACCEPT (taking coins)
  - SELECT (credit >= PRICE, waiting for a choice)
  - VEND (vend line active)
- ACCEPT + coin_valid:
  - credit <= credit + value (registered, 1-cycle latency).
  - If the new credit >= PRICE, go to SELECT the same edge.
- SELECT or VEND + coin_valid: coin not credited; coin_reject pulses the next cycle.
- SELECT + sel_valid, sel_idx < NUM_ITEMS: go to VEND. On the same edge:
  - vend[sel_idx] <= 1.
  - Countdown loads VEND_CYCLES-1.
  - If RETURN_CHANGE: change_amt <= credit-PRICE and change_valid pulses (also when the value is 0); total_acc += PRICE.
  - If !RETURN_CHANGE: total_acc += credit.
  - credit <= 0.
- SELECT + sel_valid, sel_idx >= NUM_ITEMS: sel_err pulses; stay in SELECT.
- sel_valid in ACCEPT or VEND: ignored, no error.
- VEND:
  - vend stays high exactly VEND_CYCLES cycles; busy = (state==VEND).
  - When the countdown reaches 0, vend <= 0 and go to ACCEPT; coins are accepted from the following cycle.
- cancel in ACCEPT/SELECT with RETURN_CHANGE=1 and credit>0:
  - change_amt <= credit, change_valid pulses, credit <= 0, go to ACCEPT.
  - Otherwise cancel is ignored. cancel is always ignored in VEND.
- clr_total (any state):
  - last_total <= total_acc; total_acc <= 0; credit <= 0; vend <= 0.
  - Go to ACCEPT.
  - No change is returned.
- Priority in one cycle: clr_total > sel_valid > cancel > coin_valid.
  - A coin arriving with a winning sel/cancel/clr is rejected (coin_reject pulses).
  - A coin in ACCEPT with cancel is dropped: cancel wins, coin_reject pulses.
- Arithmetic:
  - credit never exceeds PRICE+95 by construction.
  - total_acc saturates at 2^TOTAL_W-1; it never wraps.
- All pulse outputs are registered, high for exactly one cycle.

Test Plan:
- Reset, coins 25,25,10,10 -> credit 25,50,60,70; state SELECT after the 4th coin. sel_idx=1 -> vend=3'b010 for exactly 100 cycles, total_acc=70, credit=0.
- RETURN_CHANGE=1, coin 100, sel_idx=2 -> change_valid 1 cycle with change_amt=30; vend=3'b100; total_acc=70.
- RETURN_CHANGE=0, coins 25,25,25, sel 0 -> no change_valid, total_acc=75. A coin_valid mid-VEND -> coin_reject pulse, credit stays 0.
- In SELECT, sel_idx=3 (NUM_ITEMS=3) -> sel_err pulse, still SELECT. A later sel_idx=0 vends normally.
- RETURN_CHANGE=1, coins 25,10, cancel -> change_amt=35, credit=0, ACCEPT. Cancel with credit 0 -> no pulse.
- After sales total 140, clr_total asserted mid-VEND -> vend drops the next cycle, last_total=140, total_acc=0, credit=0, ACCEPT. Async reset mid-VEND -> all outputs 0 immediately.
